// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory access controller:
//   - access size encodings (SIZE_B / SIZE_H / SIZE_W, SIZE_X is illegal)
//   - the controller state enum
//   - is_aligned(): true when an access of the given size may start at the
//     given byte offset within a word (always false for the illegal size)
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Bytes go anywhere, halves need an even offset, words need offset 0.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~lo[0];
            SIZE_W:  ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit
// Purely combinational little-endian lane logic.
//   word        : memory word as read from the memory
//   lo          : byte offset inside the word (request address bits [1:0])
//   size        : access size (SIZE_B / SIZE_H / SIZE_W)
//   zero_ext    : 1 = zero-extend a sub-word load, 0 = sign-extend
//   wdata       : right-aligned store data
//   load_value  : addressed lane of word, extended to 32 bits
//   merged_word : word with the addressed lane replaced by wdata
// Byte n lives in bits [8n+7:8n]; a half is [15:0] when lo[1]=0, else [31:16].
module mem_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_fill;
    logic        half_fill;

    always_comb begin
        byte_lane = word[7:0];
        case (lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = lo[1] ? word[31:16] : word[15:0];
        // Extension bit is the MSB of the extracted lane unless zero-extending.
        byte_fill = ~zero_ext & byte_lane[7];
        half_fill = ~zero_ext & half_lane[15];
    end

    always_comb begin
        load_value  = word;
        merged_word = wdata;
        case (size)
            SIZE_B: begin
                load_value  = {{24{byte_fill}}, byte_lane};
                merged_word = word;
                case (lo)
                    2'd0:    merged_word[7:0]   = wdata[7:0];
                    2'd1:    merged_word[15:8]  = wdata[7:0];
                    2'd2:    merged_word[23:16] = wdata[7:0];
                    default: merged_word[31:24] = wdata[7:0];
                endcase
            end
            SIZE_H: begin
                load_value  = {{16{half_fill}}, half_lane};
                merged_word = word;
                if (lo[1]) begin
                    merged_word[31:16] = wdata[15:0];
                end else begin
                    merged_word[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_value  = word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Multi-cycle load/store initiator between the CPU datapath and a
// word-addressed memory. One request at a time; sub-word stores use
// read-modify-write, sub-word loads are extracted and extended, and
// misaligned or illegal-size requests are answered with an error without
// any memory strobe.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   req_valid/ready : request handshake (see below)
//   req_write       : 1 = store, 0 = load
//   req_size        : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    : loads only, 1 = zero-extend
//   req_addr        : byte address
//   req_wdata       : right-aligned store data
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : load result (0 for stores and errors)
//   resp_err        : qualifies resp_valid, 1 = misaligned / illegal size
//   addr, din       : memory word address and write data
//   mem_read        : memory read strobe (dout valid combinationally)
//   mem_write       : memory write strobe (memory writes on posedge)
//   dout            : memory read data
//
// Handshake: a request transfers on a posedge where req_valid && req_ready
// are both 1. req_ready is high only in IDLE, so the request fields are
// sampled exactly once per transaction and ignored at every other edge.
// The response is the single cycle with resp_valid=1; it has no back-pressure.
//
// Every output is either a register or a decode of the state register; all
// of them are forced to zero while reset is high so an interrupted STORE
// never reaches the memory.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr,
    output logic [31:0] din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] dout
);

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [31:0] din_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_ok;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign req_ok = is_aligned(req_size, req_addr[1:0]);

    // Lane unit always looks at the live memory word; its result is only
    // captured in LOAD (extracted value) and RMW_RD (merged store word).
    mem_lane_unit u_lane (
        .word        (dout),
        .lo          (lo_q),
        .size        (size_q),
        .zero_ext    (unsigned_q),
        .wdata       (wdata_q),
        .load_value  (lane_load),
        .merged_word (lane_merged)
    );

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!req_ok) begin
                        state_nxt = RESP;
                    end else if (!req_write) begin
                        state_nxt = LOAD;
                    end else if (req_size == SIZE_W) begin
                        state_nxt = STORE;
                    end else begin
                        state_nxt = RMW_RD;
                    end
                end
            end
            LOAD:    state_nxt = RESP;
            RMW_RD:  state_nxt = STORE;
            STORE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            lo_q       <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            din_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= {req_addr[31:2], 2'b00};
                        lo_q       <= req_addr[1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
                        // A word store goes straight to STORE, so its data
                        // is the write data as given.
                        din_q      <= req_wdata;
                        rdata_q    <= '0;
                        err_q      <= ~req_ok;
                    end
                end
                LOAD: begin
                    rdata_q <= lane_load;
                end
                RMW_RD: begin
                    din_q <= lane_merged;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode.
    assign req_ready  = ~reset & (state == IDLE);
    assign mem_read   = ~reset & ((state == LOAD) | (state == RMW_RD));
    assign mem_write  = ~reset & (state == STORE);
    assign resp_valid = ~reset & (state == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = reset ? '0 : rdata_q;
    assign addr       = reset ? '0 : addr_q;
    assign din        = reset ? '0 : din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 64-word memory model, a driver task, a
// per-cycle expected-trace queue built from load/store rules, and a single
// compare process on the falling edge.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        resp;
        logic        err;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rdata;
    } step_t;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] addr;
    logic [31:0] din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] dout;

    mem_access_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .addr         (addr),
        .din          (din),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .dout         (dout)
    );

    // Memory the DUT talks to, and the bench's own reference copy.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    assign dout = mem_read ? mem[addr[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write) mem[addr[7:2]] <= din;
    end

    // Scoreboard
    step_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: one expected step per busy cycle, idle outputs otherwise.
    step_t cur;
    always @(negedge clk) begin
        if (reset) begin
            check("rst_req_ready",  {31'b0, req_ready},  0);
            check("rst_resp_valid", {31'b0, resp_valid}, 0);
            check("rst_resp_err",   {31'b0, resp_err},   0);
            check("rst_resp_rdata", resp_rdata,          0);
            check("rst_addr",       addr,                0);
            check("rst_din",        din,                 0);
            check("rst_mem_read",   {31'b0, mem_read},   0);
            check("rst_mem_write",  {31'b0, mem_write},  0);
        end else if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("busy_req_ready", {31'b0, req_ready},  0);
            check("mem_read",       {31'b0, mem_read},   {31'b0, cur.rd});
            check("mem_write",      {31'b0, mem_write},  {31'b0, cur.wr});
            check("resp_valid",     {31'b0, resp_valid}, {31'b0, cur.resp});
            if (cur.rd || cur.wr) check("addr", addr, cur.a);
            if (cur.wr)           check("din", din, cur.d);
            if (cur.resp) begin
                check("resp_err",   {31'b0, resp_err}, {31'b0, cur.err});
                check("resp_rdata", resp_rdata, cur.rdata);
            end
        end else begin
            check("idle_req_ready",  {31'b0, req_ready},  1);
            check("idle_mem_read",   {31'b0, mem_read},   0);
            check("idle_mem_write",  {31'b0, mem_write},  0);
            check("idle_resp_valid", {31'b0, resp_valid}, 0);
        end
    end

    // Driver + reference model. The model derives the expected cycle trace
    // from the access rules; pin_en compares the model's data result with a
    // hand-computed value. abort asserts reset during the first busy cycle.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic pin_en, input logic [31:0] pin,
                          input logic abort);
        int          idx;
        int          sh;
        logic        ok;
        logic        sgn;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] wa;
        step_t       s;

        do begin
            @(negedge clk);
            #2;
        end while (exp_q.size() != 0);
        req_valid = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        #2;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);

        idx  = int'(a[7:2]);
        sh   = int'(a[1:0]) * 8;
        word = ref_mem[idx];
        wa   = {a[31:2], 2'b00};
        ok   = !((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
        mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << sh;
        s    = '0;
        if (!ok) begin
            s.resp = 1'b1; s.err = 1'b1; s.rdata = 0;
            exp_q.push_back(s);
        end else if (!wr) begin
            val = (word & mask) >> sh;
            sgn = (sz == 2'b00) ? val[7] : val[15];
            if (!uns && sz != 2'b10 && sgn) val = val | ~(mask >> sh);
            if (pin_en) check("model_pin_load", val, pin);
            s.rd = 1'b1; s.a = wa;
            exp_q.push_back(s);
            s = '0; s.resp = 1'b1; s.rdata = val;
            exp_q.push_back(s);
        end else if (sz == 2'b10) begin
            if (pin_en) check("model_pin_store", wd, pin);
            ref_mem[idx] = wd;
            s.wr = 1'b1; s.a = wa; s.d = wd;
            exp_q.push_back(s);
            s = '0; s.resp = 1'b1;
            exp_q.push_back(s);
        end else begin
            val = (word & ~mask) | ((wd << sh) & mask);
            if (pin_en) check("model_pin_merge", val, pin);
            s.rd = 1'b1; s.a = wa;
            exp_q.push_back(s);
            if (!abort) begin
                ref_mem[idx] = val;
                s = '0; s.wr = 1'b1; s.a = wa; s.d = val;
                exp_q.push_back(s);
                s = '0; s.resp = 1'b1;
                exp_q.push_back(s);
            end
        end

        // While busy, present random junk that must be ignored.
        #1;
        req_valid    = abort ? 1'b0 : 1'($urandom_range(0, 1));
        req_write    = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;

        if (abort) begin
            @(negedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1 reset = 1'b0;
        end
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
        end
        mem[4] = 32'h8899AABB;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // Directed cases from the access rules.
        do_req(0, 2'b00, 0, 32'h11, 32'h0, 1, 32'hFFFF_FFAA, 0);
        do_req(0, 2'b01, 1, 32'h12, 32'h0, 1, 32'h0000_8899, 0);
        do_req(0, 2'b01, 0, 32'h12, 32'h0, 1, 32'hFFFF_8899, 0);
        do_req(1, 2'b00, 0, 32'h13, 32'hFFFF_FF5C, 1, 32'h5C99_AABB, 0);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h5C99_AABB, 0);
        do_req(1, 2'b10, 0, 32'h20, 32'h1234_5678, 1, 32'h1234_5678, 0);
        do_req(0, 2'b10, 0, 32'h20, 32'h0, 1, 32'h1234_5678, 0);
        do_req(0, 2'b10, 0, 32'h22, 32'h0, 0, 32'h0, 0);
        do_req(0, 2'b11, 0, 32'h10, 32'h0, 0, 32'h0, 0);
        do_req(1, 2'b01, 0, 32'h11, 32'hBEEF, 0, 32'h0, 0);
        // Reset during RMW_RD of a byte store; word must be untouched.
        do_req(1, 2'b00, 0, 32'h10, 32'h0000_00EE, 1, 32'h5C99_AAEE, 1);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h5C99_AABB, 0);
        do_req(1, 2'b01, 0, 32'h16, 32'hAAAA_8001, 1, {16'h8001, ref_mem[5][15:0]}, 0);
        do_req(0, 2'b01, 0, 32'h16, 32'h0, 1, 32'hFFFF_8001, 0);

        // Randomized traffic, mostly aligned.
        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) sz = 2'b11;
            else if (sz == 2'b11) sz = 2'b10;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 0, 32'h0, 0);
        end

        do begin
            @(negedge clk);
            #2;
        end while (exp_q.size() != 0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            check("final_mem", mem[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory initiator that sits between the CPU datapath and the word-addressed unified memory. Accepts one load/store request at a time (byte, half, word), drives the memory's address, data, and read/write strobes, and returns a one-cycle response. Sub-word stores use read-modify-write. Sub-word loads are extracted and sign- or zero-extended. Misaligned accesses are rejected without touching memory.

## Interface
Parameters:
- none (data and address width fixed at 32)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid; 1 = misaligned or illegal size
- addr  out  32  memory byte address, always {req_addr[31:2],2'b00}
- din  out  32  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe; memory writes on posedge clk
- dout  in  32  memory read data; combinational from addr, 0 when mem_read is low

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 11 → RESP with err=1.
  - Load → LOAD.
  - Word store → STORE with din=wdata.
  - Sub-word store → RMW_RD.
- LOAD: mem_read=1. Register the extracted lane of dout into resp_rdata. → RESP.
- RMW_RD: mem_read=1. Register the merged word (dout with the addressed lane replaced by wdata) as din. → STORE.
- STORE: mem_write=1, din driven from register. → RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0. → IDLE.
- Little-endian lanes:
  - byte n = bits [8n+7:8n], selected by addr[1:0].
  - half selected by addr[1]: 0 = [15:0], 1 = [31:16].
- Sign extension uses the MSB of the extracted lane.
- mem_read and mem_write are never high in the same cycle. addr is stable throughout LOAD, RMW_RD, and STORE.
- No request is accepted outside IDLE. req_* values are ignored unless req_valid && req_ready.

## Timing
- Accept edge = T0.
- Load: LOAD in cycle 1, resp_valid in cycle 2.
- Word store: STORE in cycle 1, resp_valid in cycle 2.
- Sub-word store: RMW_RD in cycle 1, STORE in cycle 2, resp_valid in cycle 3.
- Error: resp_valid with resp_err=1 in cycle 1. No mem_read or mem_write.
- Back-to-back requests: the next accept is possible in the cycle after RESP, so throughput is at most one request per 3 cycles (load or word store).
- Reset behaviour:
  - While reset is high: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, addr=0, din=0, mem_read=0, mem_write=0.
  - req_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: the transaction is abandoned. No mem_write is issued (even if in STORE) and no resp_valid is produced.
- Outputs are registered or decoded from state only. No combinational path from req_* to memory strobes.

## Structure
- Shared package mem_ctrl_pkg holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W
  - the state enum
  - the alignment-check function
- One combinational sub-module, mem_lane_unit:
  - inputs: word, addr[1:0], size, unsigned, wdata
  - outputs: extracted/extended load value, merged store word
- The FSM and registers stay in mem_access_ctrl.

## Test plan
Memory is preloaded with word 0x10 = 0x8899AABB.
- Load byte signed at 0x11 → mem_read for 1 cycle at addr 0x10, resp_valid in cycle 2, rdata=0xFFFFFFAA, err=0, mem_write never asserted.
- Load half unsigned at 0x12 → rdata=0x00008899. Same request with req_unsigned=0 → 0xFFFF8899.
- Store byte 0x5C at 0x13 → mem_read in cycle 1, mem_write in cycle 2 with din=0x5C99AABB, resp in cycle 3. Then load word 0x10 → 0x5C99AABB.
- Store word 0x12345678 at 0x20 → single mem_write cycle, no mem_read, resp in cycle 2. Reload returns 0x12345678.
- Load word at 0x22 and req_size=11 at 0x10 → resp_err=1 in cycle 1, rdata=0, no memory strobes.
- Assert reset during RMW_RD of a byte store → no mem_write, no resp_valid, memory word unchanged after reload. req_ready=1 in the first cycle after reset drops.
